// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  mul_pkg
//  Shared types, widths and the operand-shift helper for mul4_seq_arbiter.
//  Revision: 1.0
// ============================================================================
package mul_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Partial product of one multiplier bit: the zero-extended multiplicand
    // moved to that bit's weight.
    function automatic logic [PROD_W-1:0] shift_operand(
        input logic [OP_W-1:0] x,
        input logic [1:0]      sh
    );
        return {{(PROD_W-OP_W){1'b0}}, x} << sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/Full_Adder_by8.sv
`default_nettype none
// ============================================================================
//  Full_Adder_by8
//  8-bit ripple-carry adder built from a chain of single-bit full adders.
//  Revision: 1.0
// ============================================================================
module Full_Adder_by8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar i;
    for (i = 0; i < 8; i++) begin : g_bit
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[8];

endmodule
`default_nettype wire

// File: rtl/mul4_seq_arbiter.sv
`default_nettype none
// ============================================================================
//  mul4_seq_arbiter
//  Two-requester round-robin front end to a 4x4 shift-add multiplier that
//  reuses one 8-bit ripple adder over four cycles.
//  Revision: 1.0
// ============================================================================
module mul4_seq_arbiter
    import mul_pkg::*;
#(
    parameter int N_ITER = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   x0,
    input  logic [OP_W-1:0]   y0,
    input  logic [OP_W-1:0]   x1,
    input  logic [OP_W-1:0]   y1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              res_valid,
    output logic [PROD_W-1:0] res,
    output logic              res_id,
    input  logic              res_ready
);

    localparam logic [1:0] C_LAST_IT = 2'(N_ITER - 1);

    mul_state_t          state_q, state_d;
    logic [1:0]          it_q, it_d;
    logic [OP_W-1:0]     x_q, x_d;
    logic [OP_W-1:0]     y_q, y_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic                id_q, id_d;
    logic                last_id_q, last_id_d;

    logic [PROD_W-1:0]   w_b;
    logic [PROD_W-1:0]   w_sum;
    logic                w_cout;
    logic                w_pick1;

    assign w_b = y_q[it_q] ? shift_operand(x_q, it_q) : '0;

    // Carry-out cannot be set: the running sum never exceeds 15*15.
    Full_Adder_by8 u_adder (
        .i_a    (acc_q),
        .i_b    (w_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // On a tie, requester 1 wins only if requester 0 was served last.
    assign w_pick1 = req1 && (!req0 || !last_id_q);

    always_comb begin
        state_d   = state_q;
        it_d      = it_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0      = !w_pick1;
                    gnt1      = w_pick1;
                    x_d       = w_pick1 ? x1 : x0;
                    y_d       = w_pick1 ? y1 : y0;
                    acc_d     = '0;
                    it_d      = '0;
                    id_d      = w_pick1;
                    last_id_d = w_pick1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d = w_sum;
                it_d  = it_q + 2'd1;
                if (it_q == C_LAST_IT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            it_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            it_q      <= it_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

    // Result lines read zero outside DONE so partial sums never leak out.
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res       = res_valid ? acc_q : '0;
    assign res_id    = res_valid ? id_q : 1'b0;

endmodule
`default_nettype wire
